// File: rtl/score_counter.sv
// ---------------------------------------------------------------------------
// score_counter
//
// Purpose:
//   Game score keeper for the Dino Run top level. While the game is running,
//   the score advances by one point every FRAMES_PER_POINT frame pulses.
//   The score is held as four BCD digits with a ripple carry, and it
//   saturates at 9999. The digit enables implement leading-zero blanking.
//   After game over, the whole display blinks with a half-period of
//   BLINK_FRAMES frames.
//
// Optional feature:
//   Define SCORE_HISCORE_EN to add a four-digit BCD high-score register.
//   This register is updated on every RUN -> OVER transition. While
//   show_hi_i is high outside RUN, the display shows the high score.
//
// Parameters:
//   FRAMES_PER_POINT  frame pulses per score increment (1..255)
//   BLINK_FRAMES      frame pulses per blink half-period in OVER (1..255)
//
// Ports:
//   clk_25_175_i       pixel clock; all state changes on its rising edge
//   rst_ni             synchronous, active-low reset
//   frame_i            one-cycle pulse at the start of each VGA frame
//   run_i              game in progress (level)
//   clear_i            one-cycle pulse: new game, zero the score
//   show_hi_i          show the high score (only with SCORE_HISCORE_EN)
//   digitN_o           BCD value of digit N (0 = ones ... 3 = thousands)
//   digitN_en_o        enable for digit N (blanking and blink applied)
//   over_o             high while in the OVER state
// ---------------------------------------------------------------------------
module score_counter #(
  parameter int unsigned FRAMES_PER_POINT = 6,
  parameter int unsigned BLINK_FRAMES     = 30
) (
  input  logic       clk_25_175_i,
  input  logic       rst_ni,
  input  logic       frame_i,
  input  logic       run_i,
  input  logic       clear_i,
  input  logic       show_hi_i,
  output logic       digit0_en_o,
  output logic [3:0] digit0_o,
  output logic       digit1_en_o,
  output logic [3:0] digit1_o,
  output logic       digit2_en_o,
  output logic [3:0] digit2_o,
  output logic       digit3_en_o,
  output logic [3:0] digit3_o,
  output logic       over_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [7:0]  DIV_LAST   = 8'(FRAMES_PER_POINT - 1);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [15:0] SCORE_MAX  = 16'h9999;

  state_t      state;
  logic [15:0] score;
  logic [7:0]  div_cnt;
  logic [7:0]  blink_cnt;
  logic        blink_on;
  logic [15:0] shown;
  logic        lit;

`ifdef SCORE_HISCORE_EN
  logic [15:0] hi_score;
`endif

  // Add one to a packed 4-digit BCD value.
  // Each digit that is already 9 wraps to 0 and passes the carry upward.
  // The caller handles saturation at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Game FSM, frame divider, score and blink state.
  // clear_i overrides every state.
  // When the score is saturated, the divider keeps cycling.
  // Only the increment itself is dropped.
  always_ff @(posedge clk_25_175_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      score     <= '0;
      div_cnt   <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
`ifdef SCORE_HISCORE_EN
      hi_score  <= '0;
`endif
    end else if (clear_i) begin
      state     <= RUN;
      score     <= '0;
      div_cnt   <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
        end
        RUN: begin
          if (!run_i) begin
            // Game over takes precedence over a frame pulse in the same cycle.
            state     <= OVER;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
`ifdef SCORE_HISCORE_EN
            // Plain unsigned compare of packed BCD orders digits MSD first.
            if (score > hi_score) begin
              hi_score <= score;
            end
`endif
          end else if (frame_i) begin
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              if (score != SCORE_MAX) begin
                score <= bcd_inc(score);
              end
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
        end
        OVER: begin
          if (frame_i) begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              blink_on  <= ~blink_on;
            end else begin
              blink_cnt <= blink_cnt + 8'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Select which value is displayed.
  // With the high-score option, show_hi_i is honoured only outside RUN.
`ifdef SCORE_HISCORE_EN
  assign shown = (show_hi_i && (state != RUN)) ? hi_score : score;
`else
  logic unused_show_hi;
  assign unused_show_hi = show_hi_i;
  assign shown          = score;
`endif

  // The blink phase can only be off in OVER.
  // It is qualified by the state here so that other states are never dark.
  assign lit = (state != OVER) || blink_on;

  assign digit0_o = shown[3:0];
  assign digit1_o = shown[7:4];
  assign digit2_o = shown[11:8];
  assign digit3_o = shown[15:12];

  // Leading-zero blanking: a digit is lit if it or any higher digit is nonzero.
  assign digit3_en_o = lit && (shown[15:12] != 4'd0);
  assign digit2_en_o = lit && (shown[15:8]  != 8'd0);
  assign digit1_en_o = lit && (shown[15:4]  != 12'd0);
  assign digit0_en_o = lit;

  assign over_o = (state == OVER);

endmodule

// File: tb/tb_score_counter.sv
// ---------------------------------------------------------------------------
// tb_score_counter
//
// Purpose:
//   Self-checking bench for score_counter. It covers:
//   - a vector table with hand-derived expectations;
//   - directed sequences for carry, saturation, blink and clear/reset;
//   - the high-score option when SCORE_HISCORE_EN is defined;
//   - a randomized run checked against an arithmetic reference model.
//
//   Small parameter values keep the saturation climb short.
// ---------------------------------------------------------------------------
module tb_score_counter;

  localparam int FPP = 3;
  localparam int BLK = 4;

`ifdef SCORE_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       frame;
  logic       run;
  logic       clear;
  logic       show_hi;
  logic       d0_en, d1_en, d2_en, d3_en;
  logic [3:0] d0, d1, d2, d3;
  logic       over;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  // Scores are plain integers and the state is a small number:
  // 0 = idle, 1 = run, 2 = over.
  int m_score, m_div, m_blink, m_state, m_hi;
  bit m_phase;

  typedef struct {
    bit          rst_n;
    bit          clr;
    bit          run;
    bit          frame;
    logic [15:0] digits;
    logic [3:0]  en;
    bit          over;
  } vec_t;

  vec_t vecs[12];

  score_counter #(
    .FRAMES_PER_POINT(FPP),
    .BLINK_FRAMES    (BLK)
  ) dut (
    .clk_25_175_i(clk),
    .rst_ni      (rst_n),
    .frame_i     (frame),
    .run_i       (run),
    .clear_i     (clear),
    .show_hi_i   (show_hi),
    .digit0_en_o (d0_en),
    .digit0_o    (d0),
    .digit1_en_o (d1_en),
    .digit1_o    (d1),
    .digit2_en_o (d2_en),
    .digit2_o    (d2),
    .digit3_en_o (d3_en),
    .digit3_o    (d3),
    .over_o      (over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one rising edge, using the inputs currently applied.
  task automatic modelStep();
    if (!rst_n) begin
      m_score = 0; m_div = 0; m_blink = 0; m_phase = 1'b1; m_state = 0; m_hi = 0;
    end else if (clear) begin
      m_score = 0; m_div = 0; m_blink = 0; m_phase = 1'b1; m_state = 1;
    end else if (m_state == 1) begin
      if (!run) begin
        if (m_score > m_hi) m_hi = m_score;
        m_state = 2; m_blink = 0; m_phase = 1'b1;
      end else if (frame) begin
        m_div = m_div + 1;
        if (m_div == FPP) begin
          m_div = 0;
          if (m_score < 9999) m_score = m_score + 1;
        end
      end
    end else if (m_state == 2) begin
      if (frame) begin
        m_blink = m_blink + 1;
        if (m_blink == BLK) begin
          m_blink = 0;
          m_phase = !m_phase;
        end
      end
    end
  endtask

  // Expected outputs, packed as {over, en3..en0, d3, d2, d1, d0}.
  function automatic logic [20:0] expectedOut();
    int val;
    bit on;
    val = (HI_EN && show_hi && m_state != 1) ? m_hi : m_score;
    on  = (m_state != 2) || m_phase;
    return {m_state == 2, on && val >= 1000, on && val >= 100, on && val >= 10, on,
            4'(val / 1000), 4'((val / 100) % 10), 4'((val / 10) % 10), 4'(val % 10)};
  endfunction

  // Drive inputs at the falling edge, wait for the rising edge,
  // update the model, then settle before the caller checks.
  task automatic applyStimulus(input bit r, input bit c, input bit ru,
                               input bit f, input bit s);
    @(negedge clk);
    rst_n   = r;
    clear   = c;
    run     = ru;
    frame   = f;
    show_hi = s;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [20:0] exp);
    logic [20:0] act;
    act    = {over, d3_en, d2_en, d1_en, d0_en, d3, d2, d1, d0};
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply n running frame pulses and check each cycle against the model.
  task automatic runFrames(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput(name, expectedOut());
    end
  endtask

  // Apply n frame pulses in OVER and check each cycle against the model.
  task automatic overFrames(input int n, input bit s, input string name);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, s);
      checkOutput(name, expectedOut());
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; run = 1'b0; frame = 1'b0; show_hi = 1'b0;
    m_score = 0; m_div = 0; m_blink = 0; m_state = 0; m_hi = 0; m_phase = 1'b1;

    // Hand-derived vectors with FPP = 3.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0001, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0001, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0001, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 4'b0001, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 4'b0001, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 4'b0001, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 4'b0001, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 4'b0001, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 4'b0001, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0001, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 4'b0001, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 4'b0001, 1'b0};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].clr, vecs[i].run, vecs[i].frame, 1'b0);
      checkOutput($sformatf("vec%0d", i), {vecs[i].over, vecs[i].en, vecs[i].digits});
    end

    // Frame pulses in IDLE must not move the score.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("idle_frames", expectedOut());
    end
    checkOutput("idle_score", {1'b0, 4'b0001, 16'h0000});

    // Carry from 0099 to 0100, then climb to saturation.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    runFrames(99 * FPP, "climb99");
    checkOutput("score_0099", {1'b0, 4'b0011, 16'h0099});
    runFrames(FPP, "carry100");
    checkOutput("score_0100", {1'b0, 4'b0111, 16'h0100});
    runFrames((9999 - 100) * FPP, "climb9999");
    checkOutput("score_9999", {1'b0, 4'b1111, 16'h9999});
    runFrames(12 * FPP, "saturate");
    checkOutput("saturated", {1'b0, 4'b1111, 16'h9999});

    // run_i drops on the frame pulse that would increment the score.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    runFrames(2 * FPP + FPP - 1, "pre_over");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("no_inc_over", {1'b1, 4'b0001, 16'h0002});
    overFrames(BLK, 1'b0, "blink_a");
    checkOutput("blink_off", {1'b1, 4'b0000, 16'h0002});
    overFrames(BLK, 1'b0, "blink_b");
    checkOutput("blink_on", {1'b1, 4'b0001, 16'h0002});

    // Clear while in OVER at 0123, then reset in the middle of RUN.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    runFrames(123 * FPP, "climb123");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("over_0123", {1'b1, 4'b0111, 16'h0123});
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("clear_in_over", {1'b0, 4'b0001, 16'h0000});
    runFrames(4 * FPP, "run_again");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("reset_mid_run", {1'b0, 4'b0001, 16'h0000});

`ifdef SCORE_HISCORE_EN
    // Three games: the high score keeps the best result.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    runFrames(42 * FPP, "game1");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    runFrames(17 * FPP, "game2");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("show_hi_in_run", {1'b0, 4'b0011, 16'h0017});
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("hi_after_g2", {1'b1, 4'b0011, 16'h0042});
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    runFrames(50 * FPP, "game3");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("hi_after_g3", {1'b1, 4'b0011, 16'h0050});
    overFrames(BLK, 1'b1, "hi_blink");
    checkOutput("hi_blink_off", {1'b1, 4'b0000, 16'h0050});
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 39) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0);
      checkOutput("random", expectedOut());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
